bsk_com_test_filter: RTL and testbench
======================================

// Module: bsk_com_test_filter
// PURPOSE
//  Front-end for the command-test bus: samples the 16 relay feedback contacts, synchronises and
//  debounces them, and drives the filtered state onto the iComT input of the BSK PRM register block.
//  Also compares the filtered feedback with the commanded outputs (oCom of the register block) and
//  latches a per-channel fault when they disagree for longer than a timeout.
// PARAMETERS
//  WIDTH       16   number of command channels
//  PRESCALE    100  clock cycles per filter tick (>=1; 1 = tick every clock)
//  FILT        4    consecutive ticks of a new level needed to accept it (>=1)
//  MISMATCH_TO 50   ticks of command/feedback disagreement before fault latch (>=1)
// PORTS
//  iClk      in  1      system clock
//  iRes      in  1      reset, asynchronous, active-low
//  iComRaw   in  WIDTH  raw relay feedback contacts, active-low (0 = contact closed), asynchronous
//  iCom      in  WIDTH  commanded outputs, active-low (0 = command on), asynchronous to iClk
//  iClr      in  1      fault clear request, active-high, synchronous to iClk
//  oComT     out WIDTH  filtered feedback, active-high (1 = contact closed) -> register block iComT
//  oChange   out 1      one-clock pulse when any oComT bit changes
//  oFault    out WIDTH  sticky per-channel mismatch flags, active-high
//  oFaultAny out 1      OR of oFault
// BEHAVIOUR
//  Reset (iRes=0, async): oComT=0, oChange=0, oFault=0, oFaultAny=0; prescaler, all debounce and
//   mismatch counters =0; synchroniser flops load the inactive level (1) so no spurious edges on release.
//  Sync: iComRaw and iCom each pass a 2-flop synchroniser; s = ~sync(iComRaw), c = ~sync(iCom).
//  Prescaler: counts 0..PRESCALE-1, wraps to 0; tick=1 for exactly the cycle it equals PRESCALE-1.
//  Debounce, per channel i, counter d[i] (width clog2(FILT+1)):
//   - s[i]==oComT[i]: d[i]<=0 (any return to old level restarts the count).
//   - s[i]!=oComT[i] and tick: if d[i]==FILT-1 then oComT[i]<=s[i], d[i]<=0, else d[i]<=d[i]+1.
//   - latency from stable raw edge to oComT: 2 sync cycles + (FILT-1)*PRESCALE+1 .. FILT*PRESCALE cycles.
//  oChange: registered; high for the single clock in which oComT first shows a new value; several
//   channels updating on the same tick give one pulse.
//  Mismatch, per channel i, saturating counter m[i] (width clog2(MISMATCH_TO+1)):
//   - c[i]==oComT[i]: m[i]<=0.  Else on tick: m[i]<=m[i]+1, saturating at MISMATCH_TO.
//   - m[i]==MISMATCH_TO sets oFault[i] (sticky) on the following clock and holds while mismatched.
//   - iClr clears oFault[i] only for channels whose m[i]==0 that cycle; if set and clear coincide, set wins.
//  oFaultAny: registered OR of oFault next state (updates same clock as oFault).
//  Counters never wrap; all state is per-channel independent except the shared tick.
//  Reset mid-operation discards any pending debounce/mismatch count; filtering restarts from oComT=0.
// TESTING (bench parameters PRESCALE=4, FILT=3, MISMATCH_TO=5, iCom=16'hFFFF unless stated)
//  1 Assert iRes=0 with iComRaw=16'h0000 -> all outputs 0 immediately; release, hold iComRaw=16'hFFFF
//    -> oComT stays 0, no oChange pulse for 100 clocks.
//  2 iComRaw[3]<=0 and hold -> oComT[3]=1 between 11 and 14 clocks later, exactly one oChange pulse
//    aligned with the edge; other bits stay 0.
//  3 iComRaw[5] low for 8 clocks then high -> oComT[5] stays 0, no oChange; repeat with
//    iComRaw[5:4] low together for 14 clocks -> both rise on the same clock with a single oChange.
//  4 iCom[0]<=0 with iComRaw[0]=1 -> oFault[0]=1 and oFaultAny=1 within 2+5*4+1 clocks; pulse iClr
//    while still mismatched -> flags stay 1.
//  5 Then iComRaw[0]<=0 -> after debounce oComT[0]=1, oFault[0] still 1; pulse iClr -> oFault[0]=0,
//    oFaultAny=0 next clock.
//  6 iRes pulsed low for 1 clock during a debounce at d=2 and with oFault[7]=1 -> all outputs 0 at
//    once; after release, full debounce time is required again before oComT rises.

Source files
------------

// File: rtl/bsk_com_test_filter.sv
// Relay feedback front-end: synchronises and debounces the contact inputs into oComT,
// and latches sticky per-channel faults when the commanded outputs and feedback disagree too long.
module bsk_com_test_filter #(
  parameter int WIDTH       = 16,
  parameter int PRESCALE    = 100,
  parameter int FILT        = 4,
  parameter int MISMATCH_TO = 50
) (
  input  logic             iClk,
  input  logic             iRes,
  input  logic [WIDTH-1:0] iComRaw,
  input  logic [WIDTH-1:0] iCom,
  input  logic             iClr,
  output logic [WIDTH-1:0] oComT,
  output logic             oChange,
  output logic [WIDTH-1:0] oFault,
  output logic             oFaultAny
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = $clog2(FILT + 1);
  localparam int MW = $clog2(MISMATCH_TO + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(FILT - 1);
  localparam logic [MW-1:0] MIS_MAX  = MW'(MISMATCH_TO);

  function automatic logic [MW-1:0] sat_inc(input logic [MW-1:0] v);
    return (v == MIS_MAX) ? v : v + MW'(1);
  endfunction

  logic [WIDTH-1:0] raw_p0_q, raw_p0_d, raw_p1_q, raw_p1_d;
  logic [WIDTH-1:0] com_p0_q, com_p0_d, com_p1_q, com_p1_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DW-1:0]    deb_q [WIDTH];
  logic [DW-1:0]    deb_d [WIDTH];
  logic [MW-1:0]    mis_q [WIDTH];
  logic [MW-1:0]    mis_d [WIDTH];
  logic [WIDTH-1:0] comt_q, comt_d;
  logic [WIDTH-1:0] fault_q, fault_d;
  logic             change_q, change_d;
  logic             fault_any_q, fault_any_d;
  logic             tick;
  logic [WIDTH-1:0] s, c;

  always_comb begin
    // stage p0/p1: two-flop synchronisers, contacts and commands turned active-high
    raw_p0_d = iComRaw;
    raw_p1_d = raw_p0_q;
    com_p0_d = iCom;
    com_p1_d = com_p0_q;
    s        = ~raw_p1_q;
    c        = ~com_p1_q;

    tick    = (presc_q == PRE_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);

    // stage p2: per-channel debounce, mismatch timeout and sticky fault
    comt_d  = comt_q;
    fault_d = fault_q;
    for (int i = 0; i < WIDTH; i++) begin
      deb_d[i] = deb_q[i];
      mis_d[i] = mis_q[i];
      if (s[i] == comt_q[i]) begin
        deb_d[i] = '0;
      end else if (tick) begin
        if (deb_q[i] == DEB_LAST) begin
          comt_d[i] = s[i];
          deb_d[i]  = '0;
        end else begin
          deb_d[i] = deb_q[i] + DW'(1);
        end
      end
      if (c[i] == comt_q[i]) begin
        mis_d[i] = '0;
      end else if (tick) begin
        mis_d[i] = sat_inc(mis_q[i]);
      end
      // a saturated counter is never zero, so a coincident clear cannot beat the set
      if (mis_q[i] == MIS_MAX) begin
        fault_d[i] = 1'b1;
      end else if (iClr && (mis_q[i] == '0)) begin
        fault_d[i] = 1'b0;
      end
    end
    change_d    = |(comt_d ^ comt_q);
    fault_any_d = |fault_d;
  end

  always_ff @(posedge iClk or negedge iRes) begin
    if (!iRes) begin
      raw_p0_q    <= '1;
      raw_p1_q    <= '1;
      com_p0_q    <= '1;
      com_p1_q    <= '1;
      presc_q     <= '0;
      comt_q      <= '0;
      fault_q     <= '0;
      change_q    <= 1'b0;
      fault_any_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        deb_q[i] <= '0;
        mis_q[i] <= '0;
      end
    end else begin
      raw_p0_q    <= raw_p0_d;
      raw_p1_q    <= raw_p1_d;
      com_p0_q    <= com_p0_d;
      com_p1_q    <= com_p1_d;
      presc_q     <= presc_d;
      comt_q      <= comt_d;
      fault_q     <= fault_d;
      change_q    <= change_d;
      fault_any_q <= fault_any_d;
      for (int i = 0; i < WIDTH; i++) begin
        deb_q[i] <= deb_d[i];
        mis_q[i] <= mis_d[i];
      end
    end
  end

  assign oComT     = comt_q;
  assign oChange   = change_q;
  assign oFault    = fault_q;
  assign oFaultAny = fault_any_q;

endmodule

// File: tb/tb_bsk_com_test_filter.sv
// Directed bench for bsk_com_test_filter with PRESCALE=4, FILT=3, MISMATCH_TO=5.
module tb_bsk_com_test_filter;

  logic        clk;
  logic        iRes;
  logic [15:0] iComRaw;
  logic [15:0] iCom;
  logic        iClr;
  logic [15:0] oComT;
  logic        oChange;
  logic [15:0] oFault;
  logic        oFaultAny;

  int tests;
  int fails;

  bsk_com_test_filter #(
    .WIDTH(16), .PRESCALE(4), .FILT(3), .MISMATCH_TO(5)
  ) dut (
    .iClk(clk), .iRes(iRes), .iComRaw(iComRaw), .iCom(iCom), .iClr(iClr),
    .oComT(oComT), .oChange(oChange), .oFault(oFault), .oFaultAny(oFaultAny)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] raw;
    logic [15:0] com;
    int          cyc;
    logic [15:0] exp_comt;
    logic [15:0] exp_fault;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    iRes = 1'b0;
    clocks(2);
    iRes = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, pulses, seen;
    logic aligned;
    tests = 0;
    fails = 0;
    tbl[0] = '{16'hFFFF, 16'hFFFF, 20, 16'h0000, 16'h0000};
    tbl[1] = '{16'hFF00, 16'hFF00, 20, 16'h00FF, 16'h0000};
    tbl[2] = '{16'h0F0F, 16'h0F0F, 20, 16'hF0F0, 16'h0000};
    tbl[3] = '{16'hA5A5, 16'hA5A5, 20, 16'h5A5A, 16'h0000};
    tbl[4] = '{16'h0000, 16'h0000, 20, 16'hFFFF, 16'h0000};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 20, 16'h0000, 16'h0000};

    iRes = 1'b1; iComRaw = 16'h0000; iCom = 16'hFFFF; iClr = 1'b0;
    #2 iRes = 1'b0;
    #1;
    chk("t1_reset_comt", 32'(oComT), 32'h0);
    chk("t1_reset_change", 32'(oChange), 32'h0);
    chk("t1_reset_fault", 32'(oFault), 32'h0);
    chk("t1_reset_any", 32'(oFaultAny), 32'h0);
    clocks(3);
    iComRaw = 16'hFFFF;
    iRes = 1'b1;
    pulses = 0; seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (oChange) pulses++;
      if (oComT != 16'h0) seen++;
    end
    chk("t1_idle_pulses", 32'(pulses), 32'h0);
    chk("t1_idle_comt_nonzero", 32'(seen), 32'h0);

    for (int v = 0; v < 6; v++) begin
      iComRaw = tbl[v].raw;
      iCom    = tbl[v].com;
      clocks(tbl[v].cyc);
      chk($sformatf("tbl%0d_comt", v), 32'(oComT), 32'(tbl[v].exp_comt));
      chk($sformatf("tbl%0d_fault", v), 32'(oFault), 32'(tbl[v].exp_fault));
      chk($sformatf("tbl%0d_any", v), 32'(oFaultAny), 32'(|tbl[v].exp_fault));
    end

    // single channel debounce latency and pulse alignment
    iComRaw[3] = 1'b0;
    lat = 0; pulses = 0; aligned = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (oChange) pulses++;
      if (oComT[3] && lat == 0) begin
        lat = k;
        aligned = oChange;
      end
    end
    chk("t2_latency_11_14", 32'(lat >= 11 && lat <= 14), 32'h1);
    chk("t2_pulse_count", 32'(pulses), 32'h1);
    chk("t2_pulse_aligned", 32'(aligned), 32'h1);
    chk("t2_comt", 32'(oComT), 32'h0008);

    // short glitch rejected
    iComRaw[5] = 1'b0;
    pulses = 0; seen = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 8) iComRaw[5] = 1'b1;
      if (oChange) pulses++;
      if (oComT[5]) seen++;
    end
    chk("t3_glitch_comt5", 32'(seen), 32'h0);
    chk("t3_glitch_pulses", 32'(pulses), 32'h0);

    // two channels accepted together, one pulse
    iComRaw[5:4] = 2'b00;
    lat = 0; lat2 = 0; pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 14) iComRaw[5:4] = 2'b11;
      if (oChange) pulses++;
      if (oComT[4] && lat == 0) lat = k;
      if (oComT[5] && lat2 == 0) lat2 = k;
    end
    chk("t3_pair_rose", 32'(lat != 0), 32'h1);
    chk("t3_pair_same_clock", 32'(lat2), 32'(lat));
    chk("t3_pair_pulses", 32'(pulses), 32'h1);
    clocks(30);
    chk("t3_pair_fell_back", 32'(oComT), 32'h0008);

    iComRaw = 16'hFFFF; iCom = 16'hFFFF;
    do_reset();
    chk("rst_clean_any", 32'(oFaultAny), 32'h0);

    // command/feedback mismatch
    iCom[0] = 1'b0;
    lat = 0; aligned = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (oFault[0] && lat == 0) begin
        lat = k;
        aligned = oFaultAny;
      end
    end
    chk("t4_fault_latency_20_23", 32'(lat >= 20 && lat <= 23), 32'h1);
    chk("t4_any_with_fault", 32'(aligned), 32'h1);
    chk("t4_fault", 32'(oFault), 32'h0001);
    iClr = 1'b1;
    @(negedge clk);
    iClr = 1'b0;
    clocks(2);
    chk("t4_clr_blocked_fault", 32'(oFault), 32'h0001);
    chk("t4_clr_blocked_any", 32'(oFaultAny), 32'h1);

    // feedback catches up, fault stays until cleared
    iComRaw[0] = 1'b0;
    clocks(20);
    chk("t5_comt", 32'(oComT), 32'h0001);
    chk("t5_fault_sticky", 32'(oFault), 32'h0001);
    iClr = 1'b1;
    @(negedge clk);
    iClr = 1'b0;
    chk("t5_clr_fault", 32'(oFault), 32'h0000);
    chk("t5_clr_any", 32'(oFaultAny), 32'h0);

    // reset in the middle of a debounce with a fault latched
    iCom[7] = 1'b0;
    clocks(25);
    chk("t6_pre_fault7", 32'(oFault[7]), 32'h1);
    iComRaw[9] = 1'b0;
    clocks(10);
    chk("t6_pre_comt9_low", 32'(oComT[9]), 32'h0);
    #2 iRes = 1'b0;
    #1;
    chk("t6_rst_comt", 32'(oComT), 32'h0);
    chk("t6_rst_change", 32'(oChange), 32'h0);
    chk("t6_rst_fault", 32'(oFault), 32'h0);
    chk("t6_rst_any", 32'(oFaultAny), 32'h0);
    @(negedge clk);
    iRes = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (oComT[9] && lat == 0) lat = k;
    end
    chk("t6_full_debounce_11_14", 32'(lat >= 11 && lat <= 14), 32'h1);
    chk("t6_comt_after", 32'(oComT), 32'h0201);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
